jk_counter_driver: RTL and testbench
====================================

Name: jk_counter_driver

Overview:
- Excitation-side controller for a bank of external JK flip-flops: computes per-bit J/K drive so the flip-flop bank follows a mod-MODULUS up/down count sequence.
- Keeps a shadow copy of the expected flip-flop state.
- Checks the bank's fed-back Q against the shadow copy every cycle and flags divergence.
- Sits beside the flip-flop bank on the same CLK; the bank's only inputs are this block's J/K outputs.

Parameters:
- WIDTH, 4, bit width of the counter and of the flip-flop bank.
- MODULUS, 10, count range 0..MODULUS-1. Legal range is 2..2^WIDTH.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- EN  input  1  count enable.
- UP  input  1  direction: 1 = up, 0 = down.
- LOAD  input  1  synchronous load request; higher priority than EN.
- LOAD_VAL  input  WIDTH  value to load. Values >= MODULUS are clamped to MODULUS-1.
- Q_FB  input  WIDTH  Q outputs fed back from the external JK flip-flop bank.
- J  output  WIDTH  J drive to the flip-flop bank (combinational from state, COUNT and controls).
- K  output  WIDTH  K drive to the flip-flop bank (combinational).
- COUNT  output  WIDTH  registered shadow of the expected bank state.
- WRAP  output  1  combinational; high in a cycle whose next edge wraps the count.
- FAULT  output  1  registered; high while in the FAULT state.

Behaviour:
- States: INIT, RUN, FAULT. 2-bit state register.
- Reset (RST_N=0), applied asynchronously: state=INIT, COUNT=0, FAULT=0. J and K follow the INIT rule immediately. Reset asserted mid-count returns to INIT with no other side effects.
- INIT:
  - Drives J=0, K=all 1s, which forces every external flip-flop to 0 regardless of its unknown power-up value.
  - COUNT stays 0.
  - Moves to RUN on the next edge. LOAD and EN are ignored here. No fault check.
- RUN, next target N is chosen in priority order:
  - LOAD=1: N=clamp(LOAD_VAL); J=N, K=~N (forced, independent of bank state).
  - EN=1, UP=1: N = COUNT+1, or 0 if COUNT=MODULUS-1.
  - EN=1, UP=0: N = COUNT-1, or MODULUS-1 if COUNT=0.
  - EN=0: N=COUNT; J=0, K=0 (hold).
- Excitation for the count/hold cases (default style), per bit i with present state COUNT[i]:
  - COUNT[i]=0: J[i]=N[i], K[i]=0.
  - COUNT[i]=1: J[i]=0, K[i]=~N[i].
- COUNT loads N on the same edge at which the external bank samples J/K, so zero latency: Q_FB equals COUNT in every RUN cycle.
- WRAP=1 only when all of the following hold: state=RUN, LOAD=0, EN=1, and either (UP=1 and COUNT=MODULUS-1) or (UP=0 and COUNT=0).
- Fault check (RUN only):
  - If Q_FB != COUNT and LOAD=0, the next edge moves to FAULT, FAULT becomes 1 and COUNT holds.
  - If LOAD=1 in the same cycle, LOAD wins and no fault is raised, because forced J/K resynchronises the bank.
- FAULT:
  - J=0, K=0 (bank frozen). COUNT holds, EN is ignored, WRAP=0.
  - LOAD=1 drives J=N, K=~N, sets COUNT=N, clears FAULT and moves to RUN on that edge.
  - The only other exit is reset.
- Arithmetic is modulo MODULUS, done in WIDTH bits; no intermediate overflow, since the terminal values are compared before increment or decrement.

Optional Feature:
- Macro: JKDRV_TOGGLE_EN.
- Defined: the count/hold excitation uses toggle style, J[i]=K[i]=COUNT[i]^N[i] (changing bits toggle, unchanged bits get 0/0).
- Not defined: the set/reset style above is used.
- In both cases, INIT, LOAD and FAULT drive rules are unchanged, and COUNT, WRAP and FAULT behaviour is identical.

Test Plan:
- Reset release with the bank model powered up at Q=4'b1011 -> INIT cycle drives J=0000, K=1111; after one edge Q_FB=0, COUNT=0, state RUN, FAULT=0.
- EN=1, UP=1 held for 12 cycles -> COUNT runs 1..9,0,1,2; WRAP high only in the cycle with COUNT=9. At COUNT=7, J=1000, K=0111 (default style); with JKDRV_TOGGLE_EN, J=K=1111.
- EN=1, UP=0 from COUNT=0 -> next COUNT=9 with WRAP=1 that cycle. EN=0 for 3 cycles -> J=K=0000 and COUNT unchanged.
- LOAD=1, LOAD_VAL=13 -> J=1001, K=0110, next COUNT=9. LOAD=1 together with EN=1 -> load wins.
- Force the bank model Q_FB bit0 flipped while COUNT=5 -> next edge FAULT=1, J=K=0, COUNT=5 frozen, EN ignored. LOAD_VAL=3 -> COUNT=3, FAULT=0, RUN.
- A mismatch cycle coinciding with LOAD=1 (LOAD_VAL=2) -> no FAULT, COUNT=2. Assert RST_N=0 mid-count at COUNT=6 -> COUNT=0 and FAULT=0 immediately, INIT drive visible before the next edge.

Source files
------------

// File: rtl/jk_counter_driver.sv
// Excitation controller for an external JK flip-flop bank that follows a mod-MODULUS up/down count.
// Optional macro JKDRV_TOGGLE_EN selects toggle-style (J=K) excitation for count/hold cycles.
module jk_counter_driver #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic [WIDTH-1:0] Q_FB,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] COUNT,
  output logic             WRAP,
  output logic             FAULT
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  // MODULUS may equal 2^WIDTH, so the clamp compare needs one extra bit
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);

  typedef enum logic [1:0] {S_INIT = 2'd0, S_RUN = 2'd1, S_FAULT = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             fault_q, fault_d;

  logic [WIDTH-1:0] load_n, step_n, run_n;
  logic [WIDTH-1:0] cnt_j, cnt_k;

  assign load_n = ({1'b0, LOAD_VAL} >= MOD_X) ? MAX_V : LOAD_VAL;

  // Terminal values are compared before stepping, so no wrap-around arithmetic is needed
  always_comb begin
    step_n = count_q;
    if (UP) step_n = (count_q == MAX_V) ? '0 : count_q + WIDTH'(1);
    else    step_n = (count_q == '0) ? MAX_V : count_q - WIDTH'(1);
  end

  assign run_n = LOAD ? load_n : (EN ? step_n : count_q);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_exc
`ifdef JKDRV_TOGGLE_EN
    assign cnt_j[gi] = count_q[gi] ^ run_n[gi];
    assign cnt_k[gi] = count_q[gi] ^ run_n[gi];
`else
    assign cnt_j[gi] = ~count_q[gi] &  run_n[gi];
    assign cnt_k[gi] =  count_q[gi] & ~run_n[gi];
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_INIT;
      count_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    fault_d = fault_q;
    case (state_q)
      S_INIT: begin
        state_d = S_RUN;
        count_d = '0;
        fault_d = 1'b0;
      end
      S_RUN: begin
        if (LOAD) begin
          count_d = load_n;
        end else if (Q_FB != count_q) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          count_d = run_n;
        end
      end
      S_FAULT: begin
        if (LOAD) begin
          state_d = S_RUN;
          count_d = load_n;
          fault_d = 1'b0;
        end
      end
      default: begin
        state_d = S_INIT;
        count_d = '0;
        fault_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    J    = '0;
    K    = '0;
    WRAP = 1'b0;
    case (state_q)
      S_INIT: K = '1;
      S_RUN: begin
        if (LOAD) begin
          J = load_n;
          K = ~load_n;
        end else begin
          J    = cnt_j;
          K    = cnt_k;
          WRAP = EN & (UP ? (count_q == MAX_V) : (count_q == '0));
        end
      end
      S_FAULT: begin
        if (LOAD) begin
          J = load_n;
          K = ~load_n;
        end
      end
      default: begin
        J = '0;
        K = '1;
      end
    endcase
  end

  assign COUNT = count_q;
  assign FAULT = fault_q;

endmodule

// File: tb/tb_jk_counter_driver.sv
// Scoreboard bench for jk_counter_driver driving a behavioural JK flip-flop bank.
module tb_jk_counter_driver;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       EN, UP, LOAD;
  logic [3:0] LOAD_VAL, Q_FB, J, K, COUNT;
  logic       WRAP, FAULT;

  logic [3:0] bank_q = 4'b1011;
  logic [3:0] inj    = 4'b0000;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0] c, j, k;
    logic       w, f;
  } exp_t;

  exp_t sb[$];

  jk_counter_driver #(.WIDTH(4), .MODULUS(10)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .UP(UP), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .Q_FB(Q_FB), .J(J), .K(K), .COUNT(COUNT), .WRAP(WRAP), .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    for (int b = 0; b < 4; b++)
      case ({J[b], K[b]})
        2'b10:   bank_q[b] <= 1'b1;
        2'b01:   bank_q[b] <= 1'b0;
        2'b11:   bank_q[b] <= ~bank_q[b];
        default: bank_q[b] <= bank_q[b];
      endcase
  end

  assign Q_FB = bank_q ^ inj;

  task automatic cmp(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Excitation for count/hold cycles, {J,K}
  function automatic logic [7:0] exc(input logic [3:0] c, input logic [3:0] n);
`ifdef JKDRV_TOGGLE_EN
    return {c ^ n, c ^ n};
`else
    return {~c & n, c & ~n};
`endif
  endfunction

  function automatic exp_t mk(input logic [3:0] c, input logic [7:0] jk, input logic w, input logic f);
    exp_t e;
    e.c = c; e.j = jk[7:4]; e.k = jk[3:0]; e.w = w; e.f = f;
    return e;
  endfunction

  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp("count", int'(COUNT), int'(e.c));
      cmp("j",     int'(J),     int'(e.j));
      cmp("k",     int'(K),     int'(e.k));
      cmp("wrap",  int'(WRAP),  int'(e.w));
      cmp("fault", int'(FAULT), int'(e.f));
    end
  end

  task automatic step(input logic en, input logic up, input logic ld, input logic [3:0] lv,
                      input logic [3:0] fi, input exp_t e);
    EN = en; UP = up; LOAD = ld; LOAD_VAL = lv; inj = fi;
    sb.push_back(e);
    @(posedge CLK); #1;
  endtask

  logic [3:0] seq [13];

  initial begin
    seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    RST_N = 1'b0; EN = 1'b0; UP = 1'b0; LOAD = 1'b0; LOAD_VAL = 4'd0;
    #1;
    cmp("rst_count", int'(COUNT), 0);
    cmp("rst_fault", int'(FAULT), 0);
    cmp("rst_j",     int'(J),     0);
    cmp("rst_k",     int'(K),     15);
    cmp("rst_wrap",  int'(WRAP),  0);
    #1 RST_N = 1'b1;
    #1;
    cmp("init_j", int'(J), 0);
    cmp("init_k", int'(K), 15);
    cmp("init_bank", int'(Q_FB), 11);
    @(posedge CLK); #1;
    cmp("run_qfb", int'(Q_FB), 0);

    // Up count across the wrap
    for (int i = 0; i < 12; i++)
      step(1, 1, 0, 4'd0, 4'd0, mk(seq[i], exc(seq[i], seq[i+1]), seq[i] == 4'd9, 0));
    // Load 0 then down-wrap to 9
    step(0, 0, 1, 4'd0, 4'd0, mk(4'd2, 8'b0000_1111, 0, 0));
    step(1, 0, 0, 4'd0, 4'd0, mk(4'd0, exc(4'd0, 4'd9), 1, 0));
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 4'd0, 4'd0, mk(4'd9, 8'h00, 0, 0));
    // Clamped load, then load beating enable at the up-terminal value
    step(0, 0, 1, 4'd13, 4'd0, mk(4'd9, 8'b1001_0110, 0, 0));
    step(1, 1, 1, 4'd4,  4'd0, mk(4'd9, 8'b0100_1011, 0, 0));
    step(1, 1, 0, 4'd0,  4'd0, mk(4'd4, exc(4'd4, 4'd5), 0, 0));
    // Feedback mismatch at 5
    step(1, 1, 0, 4'd0,  4'b0001, mk(4'd5, exc(4'd5, 4'd6), 0, 0));
    step(1, 1, 0, 4'd0,  4'd0, mk(4'd5, 8'h00, 0, 1));
    step(1, 0, 0, 4'd0,  4'd0, mk(4'd5, 8'h00, 0, 1));
    step(0, 0, 1, 4'd3,  4'd0, mk(4'd5, 8'b0011_1100, 0, 1));
    step(1, 1, 0, 4'd0,  4'd0, mk(4'd3, exc(4'd3, 4'd4), 0, 0));
    // Mismatch coinciding with load
    step(0, 0, 1, 4'd2,  4'b0100, mk(4'd4, 8'b0010_1101, 0, 0));
    step(1, 1, 0, 4'd0,  4'd0, mk(4'd2, exc(4'd2, 4'd3), 0, 0));
    step(1, 1, 0, 4'd0,  4'd0, mk(4'd3, exc(4'd3, 4'd4), 0, 0));
    step(1, 1, 0, 4'd0,  4'd0, mk(4'd4, exc(4'd4, 4'd5), 0, 0));
    step(1, 1, 0, 4'd0,  4'd0, mk(4'd5, exc(4'd5, 4'd6), 0, 0));
    // Reset mid-count at 6
    cmp("pre_rst_count", int'(COUNT), 6);
    #1 RST_N = 1'b0;
    #1;
    cmp("mid_rst_count", int'(COUNT), 0);
    cmp("mid_rst_fault", int'(FAULT), 0);
    cmp("mid_rst_j",     int'(J),     0);
    cmp("mid_rst_k",     int'(K),     15);
    #2 RST_N = 1'b1;
    EN = 1'b0; UP = 1'b0;
    @(posedge CLK); #1;
    step(0, 0, 0, 4'd0, 4'd0, mk(4'd0, 8'h00, 0, 0));
    step(1, 0, 0, 4'd0, 4'd0, mk(4'd0, exc(4'd0, 4'd9), 1, 0));
    EN = 1'b0;
    #10;
    cmp("sb_drain", sb.size(), 0);
    cmp("final_count", int'(COUNT), 9);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
